ld_field: RTL and testbench
===========================

# ld_field

Load-side field extractor for the MIX datapath. It is the read counterpart of the store-side field merge. It takes a 31-bit MIX word (sign bit plus five 6-bit bytes) and a field spec (L:R), and returns the selected bytes right-justified with the sign rules of LDA/LDX/LDAN/LDXN. The block is multi-cycle: one byte shift per clock, bracketed by a start/stop handshake driven by the instruction sequencer.

## Interface
Parameters: none. Word layout is fixed:
- sign is bit [30]
- byte 1 is [29:24], byte 2 is [23:18], byte 3 is [17:12], byte 4 is [11:6], byte 5 is [5:0]

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only when idle
- in  input  31  memory word to extract from
- field  input  6  field spec; L = field[5:3], R = field[2:0] (8L+R encoding)
- neg  input  1  1 = LDxN, invert the resulting sign
- out  output  31  extracted word; held stable between completions
- stop  output  1  one-cycle completion pulse
- busy  output  1  high while an extraction is in progress
- err  output  1  one-cycle pulse coincident with stop when the field is invalid

## Operation
- State machine has three states: IDLE, SHIFT, MASK.
- **IDLE**, start=1:
  - Latch sign s = in[30], magnitude m = in[29:0], L, R and neg.
  - Field is invalid when L>R, L>5 or R>5. An invalid field goes straight to MASK with the invalid flag set.
  - A valid field loads cnt = 5-R. It goes to SHIFT if cnt≠0, else to MASK.
- **SHIFT**:
  - m <= m >> 6, zero fill; cnt <= cnt-1.
  - Go to MASK when cnt reaches 0 after the decrement.
- **MASK**:
  - k = R - max(L,1) + 1 bytes are kept (k=0 for (0:0)); magnitude bits above 6k are cleared.
  - Sign = s if L=0, else 0 (+).
  - Sign is inverted if neg=1, including when the magnitude is zero.
  - Register out, pulse stop next cycle, return to IDLE.
- **Invalid field:** out = 31'd0, err=1 with stop. neg is ignored.
- start while busy=1 is ignored; no queuing.
- Reset (at any time, including mid-SHIFT) gives: state IDLE, out=0, stop=0, busy=0, err=0, cnt=0, and latched registers 0. A transaction in progress is discarded with no stop.

## Timing
- Numbering: start is high in cycle 0 (sampled at the end of cycle 0).
- busy is high in cycles 1 through 5-R+1 (the SHIFT and MASK cycles). It is low in the stop cycle.
- stop and err are high in cycle 5-R+2 for a valid field; out is updated at that same edge.
  - Latency ranges from 2 cycles (R=5) to 7 cycles (R=0).
- Invalid field: one MASK cycle (cycle 1); stop and err high in cycle 2.
- A new start is accepted in the stop cycle (busy=0 there), enabling back-to-back operation.
- in, field and neg are sampled only in the start cycle. Changes afterwards have no effect.
- out changes only at completion edges and at reset.

## Test plan
Common stimulus: W = {1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5}.

- **Full and right-justified fields:**
  - W with field=6'o05 (0:5), neg=0 -> out=W; stop in cycle 2, busy high in cycle 1 only.
  - W with field=6'o15 (1:5) -> out={0, bytes 1,2,3,4,5}; stop in cycle 2.
- **Inner fields:**
  - W with field=6'o33 (3:3) -> out=31'd3 (sign +); stop in cycle 4.
  - W with field=6'o02 (0:2) -> out={1, 0,0,0,1,2}; stop in cycle 5.
- **neg:**
  - W with field=6'o00 (0:0), neg=1 -> out={0, 30'd0} (sign inverted from -); stop in cycle 7.
  - W with field=6'o45, neg=1 -> out={1, 0,0,0,4,5}.
- **Invalid fields:**
  - field=6'o42 (4:2) -> out=0, err=1 and stop=1 in cycle 2.
  - field=6'o07 (R>5) -> same response.
  - err is never high without stop.
- **Handshake and reset:**
  - start pulsed again during SHIFT of a (0:0) op -> ignored; a single stop, out matches the first op.
  - rst_n low in cycle 3 of a (0:0) op -> all outputs 0 immediately; no stop after release.
  - A start in the stop cycle -> accepted; the second result follows with the correct latency.

Source files
------------

// File: rtl/ld_field.sv
// MIX load-side field extractor: right-justifies bytes L..R of a word,
// one byte shift per clock, with LDx/LDxN sign handling.
module ld_field (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [30:0] in,
    input  logic [5:0]  field,
    input  logic        neg,
    output logic [30:0] out,
    output logic        stop,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SHIFT, MASK} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt;
    logic        s;
    logic [29:0] m;
    logic [2:0]  l, r;
    logic        ng;
    logic        inv;

    logic [2:0]  fld_l, fld_r;
    logic        bad;
    logic [2:0]  lmax;
    logic [3:0]  k;
    logic [4:0]  sh;
    logic [30:0] keep;
    logic        sgn;

    assign fld_l = field[5:3];
    assign fld_r = field[2:0];
    assign bad   = (fld_l > fld_r) || (fld_l > 3'd5) || (fld_r > 3'd5);
    assign busy  = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (bad || fld_r == 3'd5) ? MASK : SHIFT;
            SHIFT:   if (cnt == 3'd1) state_next = MASK;
            MASK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // k = R - max(L,1) + 1 bytes kept; (0:0) yields k = 0 and an all-zero mask
    always_comb begin
        lmax = (l == 3'd0) ? 3'd1 : l;
        k    = {1'b0, r} - {1'b0, lmax} + 4'd1;
        sh   = 5'(k) * 5'd6;
        keep = (31'd1 << sh) - 31'd1;
        sgn  = ((l == 3'd0) ? s : 1'b0) ^ ng;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            s    <= 1'b0;
            m    <= '0;
            l    <= '0;
            r    <= '0;
            ng   <= 1'b0;
            inv  <= 1'b0;
            out  <= '0;
            stop <= 1'b0;
            err  <= 1'b0;
        end else begin
            stop <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s   <= in[30];
                        m   <= in[29:0];
                        l   <= fld_l;
                        r   <= fld_r;
                        ng  <= neg;
                        inv <= bad;
                        cnt <= bad ? 3'd0 : 3'd5 - fld_r;
                    end
                end
                SHIFT: begin
                    m   <= m >> 6;
                    cnt <= cnt - 3'd1;
                end
                MASK: begin
                    out  <= inv ? '0 : {sgn, m & keep[29:0]};
                    stop <= 1'b1;
                    err  <= inv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ld_field.sv
// Self-checking bench for ld_field: directed cases plus randomized
// operations checked against an arithmetic field-extraction model.
module tb_ld_field;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [30:0] in = '0;
    logic [5:0]  field = '0;
    logic        neg = 1'b0;
    logic [30:0] out;
    logic        stop;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [30:0] prev_out = '0;

    localparam logic [30:0] W = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};

    ld_field dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(in), .field(field),
        .neg(neg), .out(out), .stop(stop), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [5:0] f);
        int lf = int'(f[5:3]);
        int rf = int'(f[2:0]);
        return (lf > rf) || (lf > 5) || (rf > 5);
    endfunction

    // Extract bytes max(L,1)..R by plain base-64 arithmetic
    function automatic logic [30:0] ref_out(input logic [30:0] w, input logic [5:0] f, input logic n);
        int lf = int'(f[5:3]);
        int rf = int'(f[2:0]);
        longint unsigned mag = 0;
        logic sg;
        if (ref_bad(f)) return '0;
        for (int i = (lf == 0) ? 1 : lf; i <= rf; i++)
            mag = mag * 64 + ((longint'(w[29:0]) >> (6 * (5 - i))) & 63);
        sg = ((lf == 0) ? w[30] : 1'b0) ^ n;
        return {sg, mag[29:0]};
    endfunction

    // Called at a negedge; start is driven in this cycle (cycle 0).
    // Returns at the negedge of the stop cycle. spur>0 pulses start then.
    task automatic do_op(input logic [30:0] w, input logic [5:0] f, input logic n,
                         input int spur, input string tag);
        logic [30:0] exp_out = ref_out(w, f, n);
        bit          exp_bad = ref_bad(f);
        int          lat = exp_bad ? 2 : (5 - int'(f[2:0]) + 2);
        bit          done = 0;
        start = 1'b1; in = w; field = f; neg = n;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            in = 31'($urandom); field = 6'($urandom); neg = 1'($urandom);
            check({tag, ":busy"}, 32'(busy), 32'(c < lat));
            check({tag, ":stop"}, 32'(stop), 32'(c == lat));
            check({tag, ":err"},  32'(err),  32'(c == lat && exp_bad));
            if (c == lat) begin
                check({tag, ":out"}, 32'(out), 32'(exp_out));
                prev_out = exp_out;
                done = 1;
            end else begin
                check({tag, ":hold"}, 32'(out), 32'(prev_out));
                if (c == spur) start = 1'b1;
            end
        end
        if (!done) check({tag, ":timeout"}, 32'd1, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        logic [5:0] f;
        repeat (2) @(negedge clk);
        check("rst_out",  32'(out),  32'd0);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(W, 6'o05, 1'b0, 0, "full");      @(negedge clk);
        do_op(W, 6'o15, 1'b0, 0, "r1_5");      @(negedge clk);
        do_op(W, 6'o33, 1'b0, 0, "b3_3");      @(negedge clk);
        do_op(W, 6'o02, 1'b0, 0, "b0_2");      @(negedge clk);
        do_op(W, 6'o00, 1'b1, 0, "neg0_0");    @(negedge clk);
        do_op(W, 6'o45, 1'b1, 0, "neg4_5");    @(negedge clk);
        do_op(W, 6'o42, 1'b1, 0, "bad4_2");    @(negedge clk);
        do_op(W, 6'o07, 1'b0, 0, "bad0_7");    @(negedge clk);
        do_op(W, 6'o66, 1'b0, 0, "bad6_6");    @(negedge clk);

        do_op(W, 6'o00, 1'b0, 2, "spur");      @(negedge clk);
        check("spur_idle", 32'(stop), 32'd0);

        // Reset in cycle 3 of a (0:0) op
        start = 1'b1; in = W; field = 6'o00; neg = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",  32'(out),  32'd0);
        check("mid_rst_stop", 32'(stop), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err",  32'(err),  32'd0);
        prev_out = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_rst_stop", 32'(stop), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // Back-to-back: second start issued in the stop cycle
        do_op(W, 6'o13, 1'b0, 0, "b2b_a");
        do_op(W, 6'o05, 1'b1, 0, "b2b_b");
        do_op(31'h2aaa_5555, 6'o24, 1'b0, 0, "b2b_c");
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) f = 6'($urandom);
            else begin
                f[2:0] = 3'($urandom_range(0, 5));
                f[5:3] = 3'($urandom_range(0, int'(f[2:0])));
            end
            do_op(31'($urandom), f, 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, "rand");
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
